// File: rtl/countdown_timer.sv
// countdown_timer
//   Kitchen-timer countdown stage. Holds a user-set MM:SS value in BCD and
//   counts it down once every CLK_HZ clk cycles. On reaching 00:00 it raises
//   start_alarm_t to the downstream alarm stage. It pulses stop_alarm_t for one
//   cycle whenever the alarm state is left, whether by end_alarm_t or by a
//   button.
//
// Parameters
//   CLK_HZ          clk cycles per 1 s tick (>= 2)
//
// Ports
//   clk             system clock, rising edge
//   reset_n         asynchronous, active-low reset
//   btn_min         1-cycle pulse, increment minutes (SET only)
//   btn_sec         1-cycle pulse, increment seconds (SET only)
//   btn_start_stop  1-cycle pulse, start / pause / resume / silence
//   btn_clear       1-cycle pulse, clear to 00:00 and return to SET
//   end_alarm_t     alarm stage reports its sequence has finished
//   min_tens .. sec_ones  BCD display digits
//   running         high while counting down
//   start_alarm_t   level, high while in ALARM
//   stop_alarm_t    1-cycle pulse on the first cycle after leaving ALARM
module countdown_timer #(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       end_alarm_t,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       start_alarm_t,
  output logic       stop_alarm_t
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   time_q, time_nxt;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0]   time_dec;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick;
  logic          running_nxt, start_alarm_nxt, stop_alarm_nxt;

  // Minutes 00..99, wrapping to 00.
  function automatic logic [7:0] inc_minutes(input logic [7:0] m);
    logic [3:0] t, o;
    t = m[7:4];
    o = m[3:0];
    if (o >= 4'd9) begin
      o = 4'd0;
      t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Seconds 00..59, wrapping to 00 without touching the minutes.
  function automatic logic [7:0] inc_seconds(input logic [7:0] s);
    logic [3:0] t, o;
    t = s[7:4];
    o = s[3:0];
    if (o >= 4'd9) begin
      o = 4'd0;
      t = (t >= 4'd5) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // One-second BCD decrement with borrow chain. Callers only use it on a
  // nonzero value; min_tens is held at 0 instead of underflowing.
  function automatic logic [15:0] dec_time(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          if (mt != 4'd0) mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign time_dec = dec_time(time_q);

  always_comb begin
    state_nxt = state;
    time_nxt  = time_q;
    presc_nxt = presc;
    case (state)
      ST_SET: begin
        if (btn_clear) begin
          time_nxt = 16'h0000;
        end else if (btn_start_stop) begin
          // Starting from 00:00 would alarm immediately; ignore it instead.
          if (time_q != 16'h0000) begin
            state_nxt = ST_RUN;
            presc_nxt = '0;
          end
        end else begin
          if (btn_min) time_nxt[15:8] = inc_minutes(time_q[15:8]);
          if (btn_sec) time_nxt[7:0]  = inc_seconds(time_q[7:0]);
        end
      end
      ST_RUN: begin
        if (btn_clear) begin
          state_nxt = ST_SET;
          time_nxt  = 16'h0000;
          presc_nxt = '0;
        end else if (btn_start_stop) begin
          // Pause wins over a coincident tick; the prescaler holds so the
          // discarded decrement happens on the first cycle after resume.
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          presc_nxt = '0;
          time_nxt  = time_dec;
          if (time_dec == 16'h0000) state_nxt = ST_ALARM;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          state_nxt = ST_SET;
          time_nxt  = 16'h0000;
          presc_nxt = '0;
        end else if (btn_start_stop) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ALARM: begin
        time_nxt  = 16'h0000;
        presc_nxt = '0;
        if (end_alarm_t || btn_start_stop || btn_clear) state_nxt = ST_SET;
      end
      default: begin
        state_nxt = ST_SET;
        time_nxt  = 16'h0000;
        presc_nxt = '0;
      end
    endcase

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    running_nxt     = (state_nxt == ST_RUN);
    start_alarm_nxt = (state_nxt == ST_ALARM);
    stop_alarm_nxt  = (state == ST_ALARM) && (state_nxt != ST_ALARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_SET;
      time_q        <= 16'h0000;
      presc         <= '0;
      running       <= 1'b0;
      start_alarm_t <= 1'b0;
      stop_alarm_t  <= 1'b0;
    end else begin
      state         <= state_nxt;
      time_q        <= time_nxt;
      presc         <= presc_nxt;
      running       <= running_nxt;
      start_alarm_t <= start_alarm_nxt;
      stop_alarm_t  <= stop_alarm_nxt;
    end
  end

  assign min_tens = time_q[15:12];
  assign min_ones = time_q[11:8];
  assign sec_tens = time_q[7:4];
  assign sec_ones = time_q[3:0];

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLK_HZ=4.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       end_alarm_t = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, start_alarm_t, stop_alarm_t;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.CLK_HZ(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .btn_min        (btn_min),
    .btn_sec        (btn_sec),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .end_alarm_t    (end_alarm_t),
    .min_tens       (min_tens),
    .min_ones       (min_ones),
    .sec_tens       (sec_tens),
    .sec_ones       (sec_ones),
    .running        (running),
    .start_alarm_t  (start_alarm_t),
    .stop_alarm_t   (stop_alarm_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_sec(input int n);
    repeat (n) begin
      btn_sec = 1'b1; step(1); btn_sec = 1'b0;
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      btn_min = 1'b1; step(1); btn_min = 1'b0;
    end
  endtask

  task automatic press_ss();
    btn_start_stop = 1'b1; step(1); btn_start_stop = 1'b0;
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; step(1); btn_clear = 1'b0;
  endtask

  initial begin
    // Reset
    step(3);
    check("rst_digits", disp(), 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_start_alarm", start_alarm_t, 1'b0);
    check("rst_stop_alarm", stop_alarm_t, 1'b0);
    reset_n = 1'b1;
    step(1);

    // 00:03 countdown to alarm
    press_sec(3);
    check("set_003", disp(), 16'h0003);
    press_ss();
    check("run_running", running, 1'b1);
    step(3);
    check("run_hold_3cyc", disp(), 16'h0003);
    step(1);
    check("run_002", disp(), 16'h0002);
    step(4);
    check("run_001", disp(), 16'h0001);
    step(3);
    check("run_pre_alarm", start_alarm_t, 1'b0);
    step(1);
    check("run_000", disp(), 16'h0000);
    check("alarm_start", start_alarm_t, 1'b1);
    check("alarm_running", running, 1'b0);
    step(2);
    check("alarm_hold", start_alarm_t, 1'b1);
    check("alarm_no_stop", stop_alarm_t, 1'b0);

    // Leave ALARM via end_alarm_t
    end_alarm_t = 1'b1; step(1); end_alarm_t = 1'b0;
    check("end_start_alarm", start_alarm_t, 1'b0);
    check("end_stop_alarm", stop_alarm_t, 1'b1);
    step(1);
    check("end_stop_fall", stop_alarm_t, 1'b0);
    check("end_in_set", running, 1'b0);

    // 01:00 -> 00:59
    press_min(1);
    check("set_0100", disp(), 16'h0100);
    press_ss();
    step(4);
    check("borrow_0059", disp(), 16'h0059);
    press_clear();
    check("clear_run", disp(), 16'h0000);
    check("clear_run_state", running, 1'b0);

    // 10:00 -> 09:59
    press_min(10);
    check("set_1000", disp(), 16'h1000);
    press_ss();
    step(4);
    check("borrow_0959", disp(), 16'h0959);
    press_clear();

    // Seconds wrap without carry, minutes wrap
    press_min(1);
    press_sec(59);
    check("sec_59", disp(), 16'h0159);
    press_sec(1);
    check("sec_wrap", disp(), 16'h0100);
    press_clear();
    press_min(99);
    check("min_99", disp(), 16'h9900);
    press_min(1);
    check("min_wrap", disp(), 16'h0000);

    // Simultaneous min+sec, clear priority
    btn_min = 1'b1; btn_sec = 1'b1; step(1); btn_min = 1'b0; btn_sec = 1'b0;
    check("min_sec_both", disp(), 16'h0101);
    btn_clear = 1'b1; btn_min = 1'b1; step(1); btn_clear = 1'b0; btn_min = 1'b0;
    check("clear_prio", disp(), 16'h0000);

    // Pause at prescaler=2 and resume
    press_sec(5);
    press_ss();
    step(2);
    press_ss();
    check("pause_running", running, 1'b0);
    step(20);
    check("pause_frozen", disp(), 16'h0005);
    btn_sec = 1'b1; step(1); btn_sec = 1'b0;
    check("pause_sec_ignored", disp(), 16'h0005);
    press_ss();
    check("resume_running", running, 1'b1);
    check("resume_digits", disp(), 16'h0005);
    step(1);
    check("resume_p3", disp(), 16'h0005);
    step(1);
    check("resume_dec", disp(), 16'h0004);

    // Tick coinciding with pause: decrement deferred to after resume
    step(3);
    press_ss();
    check("tick_pause_discard", disp(), 16'h0004);
    step(5);
    press_ss();
    check("tick_resume_hold", disp(), 16'h0004);
    step(1);
    check("tick_resume_dec", disp(), 16'h0003);
    press_clear();

    // Leave ALARM via btn_start_stop
    press_sec(1);
    press_ss();
    step(4);
    check("alarm2_start", start_alarm_t, 1'b1);
    press_ss();
    check("alarm2_start_fall", start_alarm_t, 1'b0);
    check("alarm2_stop", stop_alarm_t, 1'b1);
    check("alarm2_running", running, 1'b0);
    step(1);
    check("alarm2_stop_fall", stop_alarm_t, 1'b0);

    // Start with 00:00 is ignored
    press_ss();
    check("zero_start_running", running, 1'b0);
    press_sec(1);
    check("zero_start_in_set", disp(), 16'h0001);
    end_alarm_t = 1'b1; step(1); end_alarm_t = 1'b0;
    check("end_alarm_ignored", stop_alarm_t, 1'b0);

    // Asynchronous reset mid-RUN
    press_sec(1);
    press_ss();
    step(2);
    check("pre_reset_running", running, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_digits", disp(), 16'h0000);
    check("async_running", running, 1'b0);
    check("async_start_alarm", start_alarm_t, 1'b0);
    check("async_stop_alarm", stop_alarm_t, 1'b0);
    step(1);
    reset_n = 1'b1;
    step(6);
    check("post_reset_idle", disp(), 16'h0000);
    check("post_reset_running", running, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Kitchen-timer countdown stage. It holds a user-set MM:SS value in BCD and counts it down at 1 Hz, derived from clk by a prescaler. On reaching 00:00 it drives the alarm stage directly downstream through `start_alarm_t` and `stop_alarm_t`, and consumes that stage's `end_alarm_t`. The digit outputs feed the display driver.

## Interface
- CLK_HZ, 1000: clk cycles per 1 s tick; ≥2.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_min  in  1  1-cycle pulse: increment minutes (SET only).
- btn_sec  in  1  1-cycle pulse: increment seconds (SET only).
- btn_start_stop  in  1  1-cycle pulse: start / pause / resume / silence.
- btn_clear  in  1  1-cycle pulse: clear to 00:00, return to SET.
- end_alarm_t  in  1  from alarm stage: alarm sequence finished.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
- running  out  1  high in RUN.
- start_alarm_t  out  1  level to alarm stage, high in ALARM.
- stop_alarm_t  out  1  1-cycle pulse to alarm stage on every ALARM exit.

## Operation
- States: SET, RUN, PAUSE, ALARM. All outputs are decoded from registers; no combinational input-to-output path.
- Reset (asynchronous) values:
  - state SET, all digits 0, prescaler 0.
  - running, start_alarm_t and stop_alarm_t all 0.
- Reset mid-operation aborts immediately to these values.
- Button priority when pulses coincide: btn_clear > btn_start_stop > btn_min/btn_sec. btn_min and btn_sec in the same cycle both apply.
- SET:
  - btn_min: minutes 00→01→…→99→00. BCD ones 9→0 carries to tens.
  - btn_sec: seconds 00→…→59→00. No carry into minutes.
  - btn_start_stop with a nonzero value: go to RUN, prescaler←0. With 00:00 it is ignored.
  - btn_clear: digits←0.
- RUN:
  - Prescaler counts 0..CLK_HZ-1 and wraps. The cycle where it equals CLK_HZ-1 is a tick, and the value decrements by one second.
  - Decrement borrow chain: sec_ones 0→9 borrows; sec_tens 0→5 borrows; min_ones 0→9 borrows; min_tens decrements.
  - The tick that produces 00:00 moves to ALARM at the same edge.
  - btn_start_stop: go to PAUSE; prescaler holds its value.
  - btn_clear: go to SET, digits←0, prescaler←0.
- PAUSE:
  - Digits and prescaler are frozen. btn_min and btn_sec are ignored.
  - btn_start_stop: resume RUN with the prescaler continuing from its held value.
  - btn_clear: go to SET, digits←0, prescaler←0.
- ALARM:
  - start_alarm_t=1 and digits stay 00:00.
  - end_alarm_t, btn_start_stop or btn_clear each move to SET.
  - On that exit edge stop_alarm_t is registered 1 for exactly one cycle, the first cycle in SET, so the alarm counter is returned to 0.
  - btn_min and btn_sec are ignored.
- end_alarm_t is ignored outside ALARM.
- No illegal BCD value (>9, or sec_tens>5) is ever produced. Digits are only loaded by the rules above.

## Timing
- Button to effect: the digit or state change is visible 1 cycle after the pulse cycle. `running` rises the cycle after btn_start_stop.
- First decrement occurs exactly CLK_HZ cycles after the edge that enters RUN from SET; subsequent decrements follow every CLK_HZ cycles.
- A pause/resume does not lose or gain prescaler counts: total RUN cycles per second stays CLK_HZ.
- start_alarm_t rises on the same edge on which the digits become 00:00. running falls on that edge.
- start_alarm_t falls and stop_alarm_t rises on the edge after end_alarm_t or the button is sampled. stop_alarm_t falls one cycle later.
- A tick coinciding with btn_start_stop in RUN: PAUSE wins and the tick's decrement is discarded. The prescaler holds at CLK_HZ-1, so the decrement occurs on the first cycle after resume.
- A tick coinciding with btn_clear: clear wins.

## Test plan (CLK_HZ=4)
- Reset, then 3×btn_sec and btn_start_stop → digits 00:03. running=1 one cycle later. Digits read 00:02, 00:01 and 00:00 at 4, 8 and 12 cycles after RUN entry. start_alarm_t=1 on the 00:00 edge.
- In ALARM, assert end_alarm_t for 1 cycle → next cycle state SET, start_alarm_t=0, stop_alarm_t=1 for exactly one cycle.
- Set 01:00 and run 1 tick → digits 00:59. Set 10:00 and run 1 tick → 09:59.
- 60×btn_sec → seconds wrap to 00 with minutes unchanged. 100×btn_min → minutes wrap to 00.
- In RUN at prescaler=2, btn_start_stop, wait 20 cycles, then btn_start_stop → digits unchanged during PAUSE. The next decrement occurs 1 cycle after the prescaler resumes.
- btn_start_stop with 00:00 → stays SET, running=0. Assert reset_n=0 mid-RUN → all outputs 0 immediately without waiting for clk.
